// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds funct3 codes, the FSM state type and the request fault check.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE,
    S_DONE
  } lsu_state_e;

  // Illegal width code or misaligned address for the requested width.
  function automatic logic req_fault(
    input logic       is_store,
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    logic illegal;
    logic misaligned;
    if (is_store)
      illegal = !(funct3 == SB || funct3 == SH || funct3 == SW);
    else
      illegal = !(funct3 == LB || funct3 == LH || funct3 == LW ||
                  funct3 == LBU || funct3 == LHU);
    misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) ||
                 (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and byte/half merge for stores.
// Purely combinational; little-endian lane numbering.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane and extend it according to the load type.
  always_comb begin
    lane_b = rd_word[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      LB:      load_data = {{24{lane_b[7]}}, lane_b};
      LH:      load_data = {{16{lane_h[15]}}, lane_h};
      LBU:     load_data = {24'h0, lane_b};
      LHU:     load_data = {16'h0, lane_h};
      default: load_data = rd_word;
    endcase
  end

  // Replace only the addressed byte/half of the previously read word.
  always_comb begin
    store_word = old_word;
    case (funct3[1:0])
      2'b00:   store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time against a word memory.
// Sub-word stores use read-modify-write; faults complete without access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEP = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] DEP_W = 32'(DEP);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        store_q, store_d;
  logic        fault_q, fault_d;
  logic [31:0] rmw_q, rmw_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] load_data;
  logic [31:0] store_word;
  logic [31:0] word_idx;

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .rd_word    (mem_rd),
    .old_word   (rmw_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Next-state and register-update logic for the access sequencer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    store_d  = store_q;
    fault_d  = fault_q;
    rmw_d    = rmw_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d   = addr;
          funct3_d = funct3;
          wdata_d  = wdata;
          store_d  = is_store;
          fault_d  = req_fault(is_store, funct3, addr[1:0]);
          if (fault_d)
            state_d = S_DONE;
          else if (!is_store)
            state_d = S_LOAD;
          else if (funct3[1:0] == 2'b10)
            state_d = S_WRITE;
          else
            state_d = S_RMW_READ;
        end
      end
      S_LOAD: begin
        rdata_d = load_data;
        state_d = S_DONE;
      end
      S_RMW_READ: begin
        rmw_d   = mem_rd;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      fault_q  <= 1'b0;
      rmw_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      store_q  <= store_d;
      fault_q  <= fault_d;
      rmw_q    <= rmw_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs come from registered state only.
  always_comb begin
    word_idx = {2'b00, addr_q[31:2]};
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    fault    = done && fault_q;
    mem_we   = (state_q == S_WRITE) && store_q;
    mem_wd   = store_word;
    mem_addr = word_idx % DEP_W;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit.
// Expected completions are queued at issue and checked at done.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          we;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.DEP(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd)
  );

  assign mem_rd = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (mem_we) mem[mem_addr[5:0]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1;
    pl_idx = 6'(idx);
    pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic access(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_f,
                        input int exp_lat, input int exp_we);
    exp_t e;
    int   cyc;
    int   wes;
    e.rd = exp_rd;
    e.flt = exp_f;
    e.lat = exp_lat;
    e.we = exp_we;
    sb_q.push_back(e);
    @(negedge clk);
    req = 1'b1;
    is_store = st;
    funct3 = f3;
    addr = a;
    wdata = wd;
    cyc = 0;
    wes = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      cyc++;
      if (mem_we) wes++;
    end while (!done && cyc < 10);
    e = sb_q.pop_front();
    check("done_seen", 32'(done), 32'd1);
    check("latency", cyc, e.lat);
    check("fault", 32'(fault), 32'(e.flt));
    check("rdata", rdata, e.rd);
    check("we_pulses", wes, e.we);
  endtask

  initial begin
    logic [4:0] done_seq;
    logic [4:0] busy_seq;
    int         cnt;
    rst = 1'b1;
    req = 1'b0;
    is_store = 1'b0;
    funct3 = 3'b000;
    addr = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    poke(5, 32'h8081_F0F1);
    poke(3, 32'h1122_3344);
    poke(8, 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b0;

    access(1'b0, LB,  32'h15, 0, 32'hFFFF_FFF0, 1'b0, 2, 0);
    access(1'b0, LHU, 32'h16, 0, 32'h0000_8081, 1'b0, 2, 0);
    access(1'b0, LH,  32'h14, 0, 32'hFFFF_F0F1, 1'b0, 2, 0);
    access(1'b0, LBU, 32'h17, 0, 32'h0000_0080, 1'b0, 2, 0);
    access(1'b0, LW,  32'h14, 0, 32'h8081_F0F1, 1'b0, 2, 0);
    access(1'b1, SB,  32'h0E, 32'h0000_00AA, 32'h8081_F0F1, 1'b0, 3, 1);
    check("sb_word3", mem[3], 32'h11AA_3344);
    access(1'b1, SW,  32'h22, 32'h1234_5678, 32'h8081_F0F1, 1'b1, 1, 0);
    check("sw_fault_mem", mem[8], 32'hDEAD_BEEF);
    access(1'b1, SH,  32'h0C, 32'h1234_5566, 32'h8081_F0F1, 1'b0, 3, 1);
    check("sh_word3", mem[3], 32'h11AA_5566);
    access(1'b1, SW,  32'h20, 32'hCAFE_F00D, 32'h8081_F0F1, 1'b0, 2, 1);
    check("sw_word8", mem[8], 32'hCAFE_F00D);
    access(1'b0, LW,  32'h120, 0, 32'hCAFE_F00D, 1'b0, 2, 0);
    access(1'b0, LH,  32'h13, 0, 32'hCAFE_F00D, 1'b1, 1, 0);
    access(1'b0, 3'b011, 32'h10, 0, 32'hCAFE_F00D, 1'b1, 1, 0);
    access(1'b1, 3'b100, 32'h10, 32'h1, 32'hCAFE_F00D, 1'b1, 1, 0);
    access(1'b1, SB,  32'h0F, 32'h0000_0077, 32'hCAFE_F00D, 1'b0, 3, 1);
    check("sb_hi_word3", mem[3], 32'h77AA_5566);

    // Reset while a sub-word store sits in RMW_READ.
    @(negedge clk);
    req = 1'b1;
    is_store = 1'b1;
    funct3 = SH;
    addr = 32'h0E;
    wdata = 32'h0000_BBBB;
    @(negedge clk);
    req = 1'b0;
    check("rmw_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || mem_we) cnt++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || mem_we) cnt++;
    end
    check("abort_quiet", cnt, 0);
    check("abort_mem", mem[3], 32'h77AA_5566);

    // Request held high: next access starts only after done.
    @(negedge clk);
    req = 1'b1;
    is_store = 1'b0;
    funct3 = LW;
    addr = 32'h14;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      done_seq[i] = done;
      busy_seq[i] = busy;
    end
    req = 1'b0;
    check("held_done", 32'(done_seq), 32'b10010);
    check("held_busy", 32'(busy_seq), 32'b11011);
    check("held_rdata", rdata, 32'h8081_F0F1);
    cnt = 0;
    while (busy && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("held_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
